minrv32_seq: RTL and testbench

Multi-cycle sequencer between the combinational RV32I core and a single shared valid/ready memory bus. It fetches each instruction over the bus and holds it stable for the core. It then performs the core's load/store on the same bus and asserts a one-cycle commit strobe. The integration uses that strobe as the enable for the core PC register and the register-file write. It also counts retired instructions and halts on trap, misalignment or bus timeout.

---
 rtl/minrv32_seq_if.sv | 31 +++
 rtl/minrv32_seq.sv | 162 ++++++++++++++++
 tb/tb_minrv32_seq.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/minrv32_seq_if.sv
// Shared valid/ready memory bus between the minrv32 sequencer (master) and memory (slave).
// One transfer completes on each clock edge where valid and ready are both high.
interface minrv32_seq_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid,
    output instr,
    output addr,
    output wdata,
    output wstrb,
    input  ready,
    input  rdata
  );

  modport slave (
    input  valid,
    input  instr,
    input  addr,
    input  wdata,
    input  wstrb,
    output ready,
    output rdata
  );
endinterface

// File: rtl/minrv32_seq.sv
// Multi-cycle sequencer for a combinational RV32I core: fetch, decode, optional data access,
// one-cycle commit strobe, retired-instruction count and halt on trap/misalign/bus timeout.
module minrv32_seq #(
  parameter bit          CATCH_MISALIGN = 1'b1,
  parameter int unsigned BUS_TIMEOUT    = 0,
  parameter logic [31:0] RESET_INSN     = 32'h0000_0013
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  minrv32_seq_if.master        bus,
  input  logic [31:0]          i_core_pc,
  output logic [31:0]          o_core_insn,
  input  logic                 i_core_trap,
  input  logic                 i_core_mem_valid,
  input  logic [31:0]          i_core_mem_addr,
  input  logic [31:0]          i_core_mem_wdata,
  input  logic [3:0]           i_core_mem_wstrb,
  input  logic [3:0]           i_core_mem_rmask,
  output logic [31:0]          o_core_mem_rdata,
  output logic                 o_core_step,
  output logic [31:0]          o_retired,
  output logic                 o_halted,
  output logic [1:0]           o_halt_cause
);

  typedef enum logic [2:0] {
    StBoot,
    StFetch,
    StDecode,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [1:0] CauseNone     = 2'd0;
  localparam logic [1:0] CauseTrap     = 2'd1;
  localparam logic [1:0] CauseMisalign = 2'd2;
  localparam logic [1:0] CauseTimeout  = 2'd3;

  state_e      r_state;
  logic [31:0] r_insn;
  logic [31:0] r_rdata;
  logic [31:0] r_retired;
  logic [1:0]  r_cause;
  logic [31:0] r_wait_cnt;

  logic [3:0]  w_mask;
  logic        w_misalign;
  logic        w_bus_active;
  logic [31:0] w_wait_next;
  logic        w_timeout;
  logic        w_commit_decode;

  // Access width is taken from whichever mask the core raised; only halfword and word can misalign.
  assign w_mask     = i_core_mem_rmask | i_core_mem_wstrb;
  assign w_misalign = CATCH_MISALIGN &&
                      (((w_mask == 4'b0011) && i_core_mem_addr[0]) ||
                       ((w_mask == 4'b1111) && (i_core_mem_addr[1:0] != 2'b00)));

  assign w_bus_active = (r_state == StFetch) || (r_state == StMem);
  assign w_wait_next  = r_wait_cnt + 32'd1;
  assign w_timeout    = (BUS_TIMEOUT != 0) && w_bus_active && !bus.ready &&
                        (w_wait_next >= BUS_TIMEOUT);

  assign w_commit_decode = (r_state == StDecode) && !i_core_trap && !i_core_mem_valid;

  always_comb begin
    bus.valid = 1'b0;
    bus.instr = 1'b0;
    bus.addr  = 32'd0;
    bus.wdata = 32'd0;
    bus.wstrb = 4'd0;
    case (r_state)
      StFetch: begin
        bus.valid = 1'b1;
        bus.instr = 1'b1;
        bus.addr  = i_core_pc;
      end
      StMem: begin
        bus.valid = 1'b1;
        bus.addr  = i_core_mem_addr;
        bus.wdata = i_core_mem_wdata;
        bus.wstrb = i_core_mem_wstrb;
      end
      default: ;
    endcase
  end

  assign o_core_insn      = r_insn;
  assign o_core_mem_rdata = r_rdata;
  assign o_core_step      = w_commit_decode || (r_state == StWb);
  assign o_retired        = r_retired;
  assign o_halted         = (r_state == StHalt);
  assign o_halt_cause     = r_cause;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StBoot;
      r_insn     <= RESET_INSN;
      r_rdata    <= 32'd0;
      r_retired  <= 32'd0;
      r_cause    <= CauseNone;
      r_wait_cnt <= 32'd0;
    end else begin
      case (r_state)
        StBoot: r_state <= StFetch;

        StFetch: begin
          if (bus.ready) begin
            r_insn     <= bus.rdata;
            r_wait_cnt <= 32'd0;
            r_state    <= StDecode;
          end else if (w_timeout) begin
            r_cause <= CauseTimeout;
            r_state <= StHalt;
          end else begin
            r_wait_cnt <= w_wait_next;
          end
        end

        StDecode: begin
          if (i_core_trap) begin
            r_cause <= CauseTrap;
            r_state <= StHalt;
          end else if (i_core_mem_valid && w_misalign) begin
            r_cause <= CauseMisalign;
            r_state <= StHalt;
          end else if (i_core_mem_valid) begin
            r_state <= StMem;
          end else begin
            r_retired <= r_retired + 32'd1;
            r_state   <= StFetch;
          end
        end

        StMem: begin
          // Stores latch rdata too; the core ignores it because no load is pending.
          if (bus.ready) begin
            r_rdata    <= bus.rdata;
            r_wait_cnt <= 32'd0;
            r_state    <= StWb;
          end else if (w_timeout) begin
            r_cause <= CauseTimeout;
            r_state <= StHalt;
          end else begin
            r_wait_cnt <= w_wait_next;
          end
        end

        StWb: begin
          r_retired <= r_retired + 32'd1;
          r_state   <= StFetch;
        end

        StHalt: r_state <= StHalt;

        default: r_state <= StBoot;
      endcase
    end
  end

endmodule

// File: tb/tb_minrv32_seq.sv
// Bench for minrv32_seq: bench plays core and memory, predicting each instruction's cycle
// timeline (fetch waits, decode, data waits, writeback) from a queue of operation records.
module tb_minrv32_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: default parameters (timeout disabled).
  logic        rst_a;
  logic [31:0] pc_a, insn_a, maddr_a, mwdata_a, mrdata_a, retired_a;
  logic        trap_a, mv_a, step_a, halted_a;
  logic [3:0]  mwstrb_a, mrmask_a;
  logic [1:0]  cause_a;
  minrv32_seq_if bus_a ();

  minrv32_seq dut_a (
    .i_clk            (clk),
    .i_reset          (rst_a),
    .bus              (bus_a),
    .i_core_pc        (pc_a),
    .o_core_insn      (insn_a),
    .i_core_trap      (trap_a),
    .i_core_mem_valid (mv_a),
    .i_core_mem_addr  (maddr_a),
    .i_core_mem_wdata (mwdata_a),
    .i_core_mem_wstrb (mwstrb_a),
    .i_core_mem_rmask (mrmask_a),
    .o_core_mem_rdata (mrdata_a),
    .o_core_step      (step_a),
    .o_retired        (retired_a),
    .o_halted         (halted_a),
    .o_halt_cause     (cause_a)
  );

  // Second instance: bus timeout of 8 wait cycles.
  logic        rst_b;
  logic [31:0] pc_b, insn_b, maddr_b, mwdata_b, mrdata_b, retired_b;
  logic        trap_b, mv_b, step_b, halted_b;
  logic [3:0]  mwstrb_b, mrmask_b;
  logic [1:0]  cause_b;
  minrv32_seq_if bus_b ();

  minrv32_seq #(
    .BUS_TIMEOUT (8)
  ) dut_b (
    .i_clk            (clk),
    .i_reset          (rst_b),
    .bus              (bus_b),
    .i_core_pc        (pc_b),
    .o_core_insn      (insn_b),
    .i_core_trap      (trap_b),
    .i_core_mem_valid (mv_b),
    .i_core_mem_addr  (maddr_b),
    .i_core_mem_wdata (mwdata_b),
    .i_core_mem_wstrb (mwstrb_b),
    .i_core_mem_rmask (mrmask_b),
    .o_core_mem_rdata (mrdata_b),
    .o_core_step      (step_b),
    .o_retired        (retired_b),
    .o_halted         (halted_b),
    .o_halt_cause     (cause_b)
  );

  // kind: 0 ALU, 1 load, 2 store, 3 misaligned access, 4 trap
  typedef struct {
    int          kind;
    logic [31:0] insn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    logic [3:0]  rmask;
    int          fwait;
    int          dwait;
  } op_t;

  op_t         q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_pc;
  logic [31:0] m_retired;

  function automatic logic [3:0] pick_mask();
    logic [3:0] masks [3];
    masks[0] = 4'b0001;
    masks[1] = 4'b0011;
    masks[2] = 4'b1111;
    return masks[$urandom_range(0, 2)];
  endfunction

  function automatic op_t make_op(int kind);
    op_t        o;
    logic [3:0] m;
    logic [31:0] base;
    o.kind  = kind;
    o.insn  = $urandom;
    o.addr  = $urandom;
    o.wdata = $urandom;
    o.rdata = $urandom;
    o.wstrb = 4'b0000;
    o.rmask = 4'($urandom);
    o.fwait = $urandom_range(0, 3);
    o.dwait = $urandom_range(0, 3);
    m       = pick_mask();
    base    = $urandom;
    if (kind == 1 || kind == 2) begin
      if (m == 4'b1111) o.addr = {base[31:2], 2'b00};
      else if (m == 4'b0011) o.addr = {base[31:1], 1'b0};
      else o.addr = base;
      o.rmask = (kind == 1) ? m : 4'b0000;
      o.wstrb = (kind == 2) ? m : 4'b0000;
    end else if (kind == 3) begin
      if ($urandom_range(0, 1) == 1) begin
        o.addr = {base[31:1], 1'b1};
        m = 4'b0011;
      end else begin
        o.addr = {base[31:2], 2'($urandom_range(1, 3))};
        m = 4'b1111;
      end
      o.rmask = ($urandom_range(0, 1) == 1) ? m : 4'b0000;
      o.wstrb = (o.rmask == 4'b0000) ? m : 4'b0000;
    end else if (kind == 4) begin
      o.insn = 32'h0000_0000;
    end
    return o;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_a = 1'b1;
    bus_a.ready = 1'b0;
    trap_a = 1'b0;
    mv_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    m_pc = 32'd0;
    m_retired = 32'd0;
  endtask

  // Plays every queued operation against dut_a and checks each cycle of its timeline.
  task automatic run_stream();
    op_t d;
    while (q.size() > 0) begin
      d = q.pop_front();
      for (int w = 0; w <= d.fwait; w++) begin
        @(negedge clk);
        pc_a     = m_pc;
        trap_a   = (d.kind == 4);
        mv_a     = (d.kind == 1 || d.kind == 2 || d.kind == 3) ||
                   (d.kind == 4 && d.rmask[0]);
        maddr_a  = d.addr;
        mwdata_a = d.wdata;
        mwstrb_a = d.wstrb;
        mrmask_a = d.rmask;
        bus_a.ready = (w == d.fwait);
        bus_a.rdata = (w == d.fwait) ? d.insn : 32'($urandom);
        #1;
        vectors++;
        if ({bus_a.valid, bus_a.instr, bus_a.addr, bus_a.wstrb, bus_a.wdata, step_a, retired_a}
            !== {1'b1, 1'b1, m_pc, 4'b0000, 32'd0, 1'b0, m_retired}) begin
          miscompares++;
          $display("FAIL fetch pc=%h: got v=%b i=%b a=%h s=%h wd=%h step=%b ret=%0d want 1 1 %h 0 0 0 %0d",
                   m_pc, bus_a.valid, bus_a.instr, bus_a.addr, bus_a.wstrb, bus_a.wdata, step_a,
                   retired_a, m_pc, m_retired);
        end
      end

      @(negedge clk);
      bus_a.ready = 1'($urandom);
      bus_a.rdata = $urandom;
      #1;
      vectors++;
      if ({bus_a.valid, step_a, insn_a, retired_a} !== {1'b0, (d.kind == 0), d.insn, m_retired}) begin
        miscompares++;
        $display("FAIL decode kind=%0d: got v=%b step=%b insn=%h ret=%0d want 0 %b %h %0d",
                 d.kind, bus_a.valid, step_a, insn_a, retired_a, (d.kind == 0), d.insn, m_retired);
      end

      if (d.kind >= 3) begin
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          bus_a.ready = 1'($urandom);
          #1;
          vectors++;
          if ({bus_a.valid, step_a, halted_a, cause_a, retired_a}
              !== {1'b0, 1'b0, 1'b1, (d.kind == 3) ? 2'd2 : 2'd1, m_retired}) begin
            miscompares++;
            $display("FAIL halt kind=%0d: got v=%b step=%b h=%b cause=%0d ret=%0d want 0 0 1 %0d %0d",
                     d.kind, bus_a.valid, step_a, halted_a, cause_a, retired_a,
                     (d.kind == 3) ? 2 : 1, m_retired);
          end
        end
        q.delete();
        return;
      end

      if (d.kind != 0) begin
        for (int w = 0; w <= d.dwait; w++) begin
          @(negedge clk);
          bus_a.ready = (w == d.dwait);
          bus_a.rdata = (w == d.dwait) ? d.rdata : 32'($urandom);
          #1;
          vectors++;
          if ({bus_a.valid, bus_a.instr, bus_a.addr, bus_a.wstrb, bus_a.wdata, step_a, retired_a}
              !== {1'b1, 1'b0, d.addr, d.wstrb, d.wdata, 1'b0, m_retired}) begin
            miscompares++;
            $display("FAIL mem: got v=%b i=%b a=%h s=%h wd=%h step=%b ret=%0d want 1 0 %h %h %h 0 %0d",
                     bus_a.valid, bus_a.instr, bus_a.addr, bus_a.wstrb, bus_a.wdata, step_a,
                     retired_a, d.addr, d.wstrb, d.wdata, m_retired);
          end
        end
        @(negedge clk);
        bus_a.ready = 1'($urandom);
        bus_a.rdata = $urandom;
        #1;
        vectors++;
        if ({bus_a.valid, step_a, mrdata_a, retired_a} !== {1'b0, 1'b1, d.rdata, m_retired}) begin
          miscompares++;
          $display("FAIL wb: got v=%b step=%b rdata=%h ret=%0d want 0 1 %h %0d",
                   bus_a.valid, step_a, mrdata_a, retired_a, d.rdata, m_retired);
        end
      end
      m_retired = m_retired + 32'd1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    bus_a.ready = 1'b1;
    bus_a.rdata = 32'h0010_0093;
    pc_a = 32'd0;
    trap_a = 1'b0;
    mv_a = 1'b0;
    maddr_a = 32'd0;
    mwdata_a = 32'd0;
    mwstrb_a = 4'd0;
    mrmask_a = 4'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if ({bus_a.valid, step_a, halted_a, cause_a, retired_a, insn_a, mrdata_a}
        !== {1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'h0000_0013, 32'd0}) begin
      miscompares++;
      $display("FAIL reset: got v=%b step=%b h=%b cause=%0d ret=%0d insn=%h rd=%h want 0 0 0 0 0 00000013 0",
               bus_a.valid, step_a, halted_a, cause_a, retired_a, insn_a, mrdata_a);
    end
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    vectors++;
    if ({bus_a.valid, step_a, halted_a} !== 3'b000) begin
      miscompares++;
      $display("FAIL boot: got v=%b step=%b h=%b want 0 0 0", bus_a.valid, step_a, halted_a);
    end
    m_pc = 32'd0;
    m_retired = 32'd0;
  endtask

  task automatic test_plan_sequence();
    op_t o;
    o = make_op(0); o.insn = 32'h0010_0093; o.fwait = 0; q.push_back(o);
    o = make_op(1); o.insn = 32'h0040_2083; o.fwait = 0; o.dwait = 3; o.addr = 32'h4;
    o.rmask = 4'b1111; o.wstrb = 4'b0000; o.rdata = 32'hDEAD_BEEF; q.push_back(o);
    o = make_op(2); o.addr = 32'h100; o.wstrb = 4'b1111; o.rmask = 4'b0000;
    o.wdata = 32'h1234_5678; q.push_back(o);
    o = make_op(0); o.fwait = 20; q.push_back(o);
    o = make_op(1); o.addr = 32'h102; o.rmask = 4'b0011; q.push_back(o);
    run_stream();
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) q.push_back(make_op($urandom_range(0, 2)));
    run_stream();
  endtask

  task automatic test_misalign();
    for (int i = 0; i < 4; i++) begin
      apply_reset();
      q.push_back(make_op($urandom_range(0, 2)));
      q.push_back(make_op(3));
      run_stream();
    end
  endtask

  task automatic test_trap();
    apply_reset();
    q.push_back(make_op(1));
    q.push_back(make_op(0));
    q.push_back(make_op(4));
    run_stream();
  endtask

  task automatic test_reset_mid_fetch();
    apply_reset();
    for (int i = 0; i < 3; i++) q.push_back(make_op($urandom_range(0, 2)));
    run_stream();
    @(negedge clk);
    pc_a = m_pc;
    mv_a = 1'b0;
    trap_a = 1'b0;
    bus_a.ready = 1'b0;
    #1;
    vectors++;
    if (bus_a.valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_abort_fetch: got valid=%b want 1", bus_a.valid);
    end
    rst_a = 1'b1;
    #1;
    vectors++;
    if ({bus_a.valid, step_a, retired_a, insn_a} !== {1'b0, 1'b0, 32'd0, 32'h0000_0013}) begin
      miscompares++;
      $display("FAIL abort: got v=%b step=%b ret=%0d insn=%h want 0 0 0 00000013",
               bus_a.valid, step_a, retired_a, insn_a);
    end
    @(negedge clk);
    rst_a = 1'b0;
    m_pc = 32'd0;
    m_retired = 32'd0;
    q.push_back(make_op(1));
    q.push_back(make_op(0));
    run_stream();
  endtask

  task automatic test_timeout();
    trap_b = 1'b0;
    mv_b = 1'b0;
    maddr_b = 32'd0;
    mwdata_b = 32'd0;
    mwstrb_b = 4'd0;
    mrmask_b = 4'd0;
    @(negedge clk);
    rst_b = 1'b0;
    bus_b.ready = 1'b0;
    #1;
    vectors++;
    if ({bus_b.valid, halted_b, retired_b} !== {1'b0, 1'b0, 32'd0}) begin
      miscompares++;
      $display("FAIL to_boot: got v=%b h=%b ret=%0d want 0 0 0", bus_b.valid, halted_b, retired_b);
    end
    // Seven waits per fetch stays just under the limit because the counter clears per transfer.
    for (int n = 0; n < 3; n++) begin
      for (int w = 0; w <= 7; w++) begin
        @(negedge clk);
        pc_b = 32'(n * 4);
        bus_b.ready = (w == 7);
        bus_b.rdata = 32'h0000_0013;
        #1;
        vectors++;
        if ({bus_b.valid, bus_b.addr, halted_b} !== {1'b1, 32'(n * 4), 1'b0}) begin
          miscompares++;
          $display("FAIL to_fetch n=%0d w=%0d: got v=%b a=%h h=%b want 1 %h 0",
                   n, w, bus_b.valid, bus_b.addr, halted_b, 32'(n * 4));
        end
      end
      @(negedge clk);
      bus_b.ready = 1'b0;
      #1;
      vectors++;
      if ({bus_b.valid, step_b, retired_b} !== {1'b0, 1'b1, 32'(n)}) begin
        miscompares++;
        $display("FAIL to_decode n=%0d: got v=%b step=%b ret=%0d want 0 1 %0d",
                 n, bus_b.valid, step_b, retired_b, n);
      end
    end
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      pc_b = 32'd12;
      bus_b.ready = 1'b0;
      #1;
      vectors++;
      if ({bus_b.valid, halted_b} !== 2'b10) begin
        miscompares++;
        $display("FAIL to_wait w=%0d: got v=%b h=%b want 1 0", w, bus_b.valid, halted_b);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus_b.ready = 1'($urandom);
      #1;
      vectors++;
      if ({bus_b.valid, step_b, halted_b, cause_b, retired_b}
          !== {1'b0, 1'b0, 1'b1, 2'd3, 32'd3}) begin
        miscompares++;
        $display("FAIL to_halt: got v=%b step=%b h=%b cause=%0d ret=%0d want 0 0 1 3 3",
                 bus_b.valid, step_b, halted_b, cause_b, retired_b);
      end
    end
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    vectors++;
    if ({bus_b.valid, halted_b, cause_b, retired_b} !== {1'b0, 1'b0, 2'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL to_reset: got v=%b h=%b cause=%0d ret=%0d want 0 0 0 0",
               bus_b.valid, halted_b, cause_b, retired_b);
    end
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    pc_b = 32'd0;
    bus_b.ready = 1'b0;
    #1;
    vectors++;
    if (bus_b.valid !== 1'b1) begin
      miscompares++;
      $display("FAIL to_refetch: got valid=%b want 1", bus_b.valid);
    end
    rst_b = 1'b1;
    #1;
    vectors++;
    if ({bus_b.valid, halted_b, retired_b, insn_b} !== {1'b0, 1'b0, 32'd0, 32'h0000_0013}) begin
      miscompares++;
      $display("FAIL to_abort: got v=%b h=%b ret=%0d insn=%h want 0 0 0 00000013",
               bus_b.valid, halted_b, retired_b, insn_b);
    end
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b1;
    bus_b.ready = 1'b0;
    bus_b.rdata = 32'd0;
    pc_b = 32'd0;
    trap_b = 1'b0;
    mv_b = 1'b0;
    maddr_b = 32'd0;
    mwdata_b = 32'd0;
    mwstrb_b = 4'd0;
    mrmask_b = 4'd0;
    test_reset();
    test_plan_sequence();
    test_random();
    test_misalign();
    test_trap();
    test_reset_mid_fetch();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
